// File: rtl/data_ram_wb_slave.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_wb_slave
// Brief    : Wishbone classic slave data RAM with big-endian byte lanes and
//            WAIT_STATES programmable ack latency. Define DRAM_WB_ERR_EN to
//            answer illegal lane masks / out-of-range addresses with err.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_wb_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int C_DEPTH = 2 ** ADDR_WIDTH;
    localparam int C_CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q,   state_d;
    logic [C_CNT_W-1:0]      cnt_q,     cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q,     idx_d;
    logic [3:0]              sel_q,     sel_d;
    logic                    we_q,      we_d;
    logic [31:0]             wdat_q,    wdat_d;
    logic                    illegal_q, illegal_d;
    logic                    ack_q,     ack_d;
    logic                    err_q,     err_d;
    logic [31:0]             rdat_q,    rdat_d;

    logic [31:0]             mem [C_DEPTH];

    logic                    w_req;
    logic                    w_req_illegal;
    logic                    w_enter_resp;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_acc_idx;
    logic [3:0]              w_acc_sel;
    logic                    w_acc_we;
    logic [31:0]             w_acc_wdat;
    logic                    w_acc_illegal;
    logic [31:0]             w_lane_mask;
    logic                    unused_adr;

    assign w_req      = wb_cyc_i & wb_stb_i;
    assign unused_adr = ^wb_adr_i;

`ifdef DRAM_WB_ERR_EN
    logic w_sel_ok;
    logic w_adr_ok;
    always_comb begin
        w_sel_ok      = wb_sel_i inside {4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                         4'b1100, 4'b0011, 4'b1111};
        w_adr_ok      = (wb_adr_i >> (ADDR_WIDTH + 2)) == 32'd0;
        w_req_illegal = !(w_sel_ok && w_adr_ok);
    end
`else
    assign w_req_illegal = 1'b0;
`endif

    // With zero wait states RESP is entered on the capture edge itself, so the
    // access fields come straight from the bus while still in IDLE.
    always_comb begin
        if (state_q == S_IDLE) begin
            w_acc_idx     = wb_adr_i[ADDR_WIDTH+1:2];
            w_acc_sel     = wb_sel_i;
            w_acc_we      = wb_we_i;
            w_acc_wdat    = wb_dat_i;
            w_acc_illegal = w_req_illegal;
        end else begin
            w_acc_idx     = idx_q;
            w_acc_sel     = sel_q;
            w_acc_we      = we_q;
            w_acc_wdat    = wdat_q;
            w_acc_illegal = illegal_q;
        end
        w_lane_mask = {{8{w_acc_sel[3]}}, {8{w_acc_sel[2]}},
                       {8{w_acc_sel[1]}}, {8{w_acc_sel[0]}}};
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        sel_d        = sel_q;
        we_d         = we_q;
        wdat_d       = wdat_q;
        illegal_d    = illegal_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        rdat_d       = 32'd0;
        w_enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    idx_d     = wb_adr_i[ADDR_WIDTH+1:2];
                    sel_d     = wb_sel_i;
                    we_d      = wb_we_i;
                    wdat_d    = wb_dat_i;
                    illegal_d = w_req_illegal;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = C_CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_d      = S_RESP;
                        w_enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Master abandoning the cycle cancels the access before any commit.
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d      = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (w_enter_resp) begin
            ack_d = !w_acc_illegal;
            err_d = w_acc_illegal;
            if (!w_acc_we && !w_acc_illegal) begin
                rdat_d = mem[w_acc_idx] & w_lane_mask;
            end
        end
    end

    assign w_mem_we = w_enter_resp & w_acc_we & !w_acc_illegal;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_sel[b]) begin
                    mem[w_acc_idx][8*b +: 8] <= w_acc_wdat[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            wdat_q    <= '0;
            illegal_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdat_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            wdat_q    <= wdat_d;
            illegal_q <= illegal_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdat_q    <= rdat_d;
        end
    end

    assign wb_dat_o = rdat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_wb_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_wb_slave
// Brief    : Three slaves (WAIT_STATES 1, 0, 3) driven with directed and random
//            Wishbone transfers, checked against a word-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_ram_wb_slave;

    localparam int NDUT = 3;
    localparam int AW   = 10;
`ifdef DRAM_WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc   [NDUT];
    logic        stb   [NDUT];
    logic        we    [NDUT];
    logic [31:0] adr   [NDUT];
    logic [3:0]  sel   [NDUT];
    logic [31:0] dat_i [NDUT];
    logic [31:0] dat_o [NDUT];
    logic        ack   [NDUT];
    logic        err   [NDUT];

    logic [31:0] model [NDUT][2**AW];
    int          n_vec    = 0;
    int          n_miscmp = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_ram_wb_slave #(
            .ADDR_WIDTH  (AW),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .wb_cyc_i (cyc[g]),
            .wb_stb_i (stb[g]),
            .wb_we_i  (we[g]),
            .wb_adr_i (adr[g]),
            .wb_sel_i (sel[g]),
            .wb_dat_i (dat_i[g]),
            .wb_dat_o (dat_o[g]),
            .wb_ack_o (ack[g]),
            .wb_err_o (err[g])
        );
    end

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic bit is_illegal(input logic [31:0] a, input logic [3:0] s);
        bit bad;
        bad = !(s inside {4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b0011, 4'b1111})
              || ((a >> (AW + 2)) != 32'd0);
        return ERR_EN && bad;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_bus(input int k);
        cyc[k] = 1'b0;
        stb[k] = 1'b0;
        we[k]  = 1'b0;
    endtask

    task automatic start_req(input int k, input bit w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] d);
        @(negedge clk);
        cyc[k]   = 1'b1;
        stb[k]   = 1'b1;
        we[k]    = w;
        adr[k]   = a;
        sel[k]   = s;
        dat_i[k] = d;
    endtask

    // One complete transfer; expectations come from the model before it is updated.
    task automatic xfer(input int k, input bit w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d, output logic [31:0] rd);
        int          idx;
        int          lat;
        bit          bad;
        bit          done;
        logic        ack_s;
        logic        err_s;
        logic [31:0] expd;
        idx  = int'(a[AW+1:2]);
        bad  = is_illegal(a, s);
        expd = (w || bad) ? 32'd0 : (model[k][idx] & lane_mask(s));
        start_req(k, w, a, s, d);
        lat   = 0;
        rd    = '0;
        done  = 1'b0;
        ack_s = 1'b0;
        err_s = 1'b0;
        for (int n = 1; n <= 20 && !done; n++) begin
            @(negedge clk);
            if (ack[k] || err[k]) begin
                lat   = n;
                rd    = dat_o[k];
                ack_s = ack[k];
                err_s = err[k];
                done  = 1'b1;
            end
        end
        idle_bus(k);
        if (!done) begin
            check_value("xfer_timeout", 32'd0, 32'd1);
        end else begin
            check_value("latency", 32'(lat), 32'(1 + ws_of(k)));
            check_value("ack", {31'd0, ack_s}, {31'd0, !bad});
            check_value("err", {31'd0, err_s}, {31'd0, bad});
            check_value("rdata", rd, expd);
            @(negedge clk);
            check_value("pulse_end", {30'd0, ack[k], err[k]}, 32'd0);
            check_value("dat_o_idle", dat_o[k], 32'd0);
        end
        if (w && !bad) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[k][idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] expd;
        logic [3:0]  s;
        bit          w;
        bit          found;
        int          n_ack;

        rst = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            idle_bus(k);
            adr[k]   = '0;
            sel[k]   = '0;
            dat_i[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check_value("reset_ack", {31'd0, ack[k]}, 32'd0);
            check_value("reset_err", {31'd0, err[k]}, 32'd0);
            check_value("reset_dat", dat_o[k], 32'd0);
        end
        rst = 1'b1;

        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < 16; i++)
                xfer(k, 1'b1, 32'(i) << 2, 4'hF, $urandom, rd);

        // Full word, then byte-lane merge and masked read, on the one-wait-state slave.
        xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd);
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, rd);
        check_value("rd_full", rd, 32'hDEADBEEF);
        xfer(0, 1'b1, 32'h11, 4'b0100, 32'h55555555, rd);
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, rd);
        check_value("rd_merged", rd, 32'hDE55BEEF);
        xfer(0, 1'b0, 32'h10, 4'b0011, 32'h0, rd);
        check_value("rd_low_lanes", rd, 32'h0000BEEF);

        xfer(0, 1'b1, 32'h20, 4'b0110, 32'hA5A5A5A5, rd);
        xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, rd);
        xfer(0, 1'b1, 32'h0000_1000, 4'hF, 32'h12345678, rd);
        xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, rd);
`ifndef DRAM_WB_ERR_EN
        check_value("alias_0x1000", rd, 32'h12345678);
`endif

        // Zero wait states with stb held: one ack every other cycle.
        expd = model[1][4] & lane_mask(4'hF);
        if (is_illegal(32'h10, 4'hF)) expd = 32'd0;
        @(negedge clk);
        cyc[1] = 1'b1;
        stb[1] = 1'b1;
        we[1]  = 1'b0;
        adr[1] = 32'h10;
        sel[1] = 4'hF;
        n_ack  = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check_value("b2b_ack", {31'd0, ack[1]}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (ack[1]) begin
                n_ack++;
                check_value("b2b_data", dat_o[1], expd);
            end
            if (i == 8) idle_bus(1);
        end
        check_value("b2b_count", 32'(n_ack), 32'd4);

        // Abort a write during WAIT on the three-wait-state slave.
        start_req(2, 1'b1, 32'h14, 4'hF, 32'hCAFEF00D);
        repeat (2) begin
            @(negedge clk);
            check_value("abort_wait_quiet", {30'd0, ack[2], err[2]}, 32'd0);
        end
        idle_bus(2);
        repeat (5) begin
            @(negedge clk);
            check_value("abort_no_ack", {30'd0, ack[2], err[2]}, 32'd0);
        end
        xfer(2, 1'b0, 32'h14, 4'hF, 32'h0, rd);

        // Reset during WAIT of a write drops the write.
        start_req(2, 1'b1, 32'h14, 4'hF, 32'h0BADF00D);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_value("rst_wait_flags", {30'd0, ack[2], err[2]}, 32'd0);
        check_value("rst_wait_dat", dat_o[2], 32'd0);
        idle_bus(2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        xfer(2, 1'b0, 32'h14, 4'hF, 32'h0, rd);

        // Reset asserted inside the ack cycle clears outputs without a clock edge.
        start_req(0, 1'b0, 32'h10, 4'hF, 32'h0);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (ack[0]) found = 1'b1;
        end
        check_value("resp_seen", {31'd0, found}, 32'd1);
        check_value("resp_data", dat_o[0], model[0][4]);
        rst = 1'b0;
        #1;
        check_value("rst_async_ack", {31'd0, ack[0]}, 32'd0);
        check_value("rst_async_dat", dat_o[0], 32'd0);
        idle_bus(0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < NDUT; k++) begin
            for (int it = 0; it < 40; it++) begin
                a = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
                if ($urandom_range(0, 3) != 0) a = a & 32'h0000_0FFF;
                s = 4'($urandom);
                w = 1'($urandom);
                xfer(k, w, a, s, $urandom, rd);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire
